tick_generator: RTL and testbench
=================================

Name: tick_generator

Overview:
Multi-channel, runtime-programmable enable-pulse generator for the 25 MHz master clock domain. Each channel emits a single-cycle tick every PERIOD cycles, either free-running (periodic) or once per start strobe (one-shot). It serves blinkers, debouncers, timeouts and sample-rate enables from one block. Per-channel period registers are writable at runtime, and a global sync strobe phase-aligns all channels.

Parameters:
N_CHANNELS, 4, number of independent tick channels (1..16)
COUNT_WIDTH, 25, width of period registers and counters (25 bits covers 1 s at 25 MHz)
DEFAULT_PERIOD, 25_000_000, reset value of every channel's period register

Ports:
clk  input  1  master clock (25 MHz)
reset  input  1  synchronous, active-high reset
period_in  input  COUNT_WIDTH  period value for load
chan_sel  input  max(1,$clog2(N_CHANNELS))  channel addressed by load
load  input  1  write period_in into period[chan_sel]
enable  input  N_CHANNELS  per-channel run enable
mode  input  N_CHANNELS  per-channel mode: 0 periodic, 1 one-shot
start  input  N_CHANNELS  per-channel one-shot launch strobe
sync  input  1  clear all counters (phase alignment)
tick  output  N_CHANNELS  registered single-cycle tick per channel
busy  output  N_CHANNELS  one-shot in flight / periodic channel running

Behaviour:
- Reset (sync, active-high, clk edge): all counters 0, all period regs = DEFAULT_PERIOD, tick = 0, busy = 0. Reset wins over every other input.
- Per channel i, state = {count[i], period[i], busy[i]}; all outputs registered, no combinational input-to-output paths.
- Running condition: enable[i] && period[i] != 0 && (mode[i]==0 || busy[i]).
- Running edge: if count == period-1, then count <= 0 and tick <= 1; else count <= count+1 and tick <= 0. Period P therefore gives exactly one tick per P cycles; P=1 gives tick high every cycle.
- Latency: a channel entering run with count=0 at edge k first drives tick high during the cycle after edge k+P-1, i.e. P cycles later.
- Not running: count holds at 0 and tick <= 0.
- period == 0: channel never ticks; busy for periodic mode is 0.
- Periodic busy = enable && period!=0, registered.
- One-shot: start[i] with enable[i] sets busy, clears count. At the wrap edge, tick <= 1 and busy <= 0 on the same edge, so no further ticks. start while busy restarts the count from 0 with no tick. start while enable=0 is ignored. start in periodic mode is ignored.
- Load: on load, period[chan_sel] <= period_in and that channel's count <= 0. A wrap on that channel at the same edge is suppressed (tick <= 0); load wins. One-shot busy is unchanged, so the one-shot restarts with the new period. chan_sel >= N_CHANNELS: no effect.
- sync: every count <= 0 and every tick <= 0 at that edge. Periods and busy are unchanged. sync has priority over load's counter clear, but the period write still happens.
- enable deassert mid-count: count <= 0, busy <= 0; a pending one-shot is cancelled without a tick.
- mode change on a channel: count <= 0, busy <= 0, no tick that edge.
- Priority per channel: reset > sync > mode change > load > start > count/wrap.
- Arithmetic: count compare uses the full COUNT_WIDTH, unsigned. period-1 is evaluated only when period != 0, so there is no underflow.

Test Plan:
- N=2, reset, load ch0 P=5, enable=2'b01 periodic -> tick[0] high 1 cycle at cycles 5,10,15 after enable; tick[1] stays 0.
- ch1 P=1 periodic -> tick[1] high every cycle. Load ch1 P=0 -> tick[1] low from the next edge; busy[1]=0.
- ch0 mode=1 P=4, pulse start -> busy high 4 cycles, single tick on the 4th, then busy=0 and no more ticks. Re-strobe start at count 2 -> tick 4 cycles after the second strobe.
- ch0 periodic P=6, load P=3 on the exact wrap edge -> no tick that edge; next ticks every 3 cycles starting 3 cycles after the load.
- Two channels P=4 and P=6 out of phase, pulse sync -> both tick together 12 cycles later; tick=0 on the sync edge.
- Assert reset mid one-shot (count=2) -> tick=0, busy=0, period regs back to DEFAULT_PERIOD on the next edge; no spurious tick afterwards.

Source files
------------

// File: rtl/tick_generator_if.sv
// Control/status bundle for tick_generator: period programming, run controls
// and the per-channel tick/busy outputs.
interface tick_generator_if #(
  parameter int N_CHANNELS  = 4,
  parameter int COUNT_WIDTH = 25
);
  localparam int SEL_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

  logic [COUNT_WIDTH-1:0] period_in;
  logic [SEL_W-1:0]       chan_sel;
  logic                   load;
  logic [N_CHANNELS-1:0]  enable;
  logic [N_CHANNELS-1:0]  mode;
  logic [N_CHANNELS-1:0]  start;
  logic                   sync;
  logic [N_CHANNELS-1:0]  tick;
  logic [N_CHANNELS-1:0]  busy;

  modport master (
    output period_in, chan_sel, load, enable, mode, start, sync,
    input  tick, busy
  );

  modport slave (
    input  period_in, chan_sel, load, enable, mode, start, sync,
    output tick, busy
  );
endinterface

// File: rtl/tick_generator.sv
// Multi-channel programmable tick generator: periodic or one-shot single-cycle
// enables, runtime-loadable periods, global phase-alignment strobe.
module tick_lane #(
  parameter int COUNT_WIDTH    = 25,
  parameter int DEFAULT_PERIOD = 25_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sync,
  input  logic                   wr,
  input  logic [COUNT_WIDTH-1:0] period_in,
  input  logic                   enable,
  input  logic                   mode,
  input  logic                   start,
  output logic                   tick,
  output logic                   busy
);
  localparam logic [COUNT_WIDTH-1:0] DEF_P = COUNT_WIDTH'(DEFAULT_PERIOD);
  localparam logic [COUNT_WIDTH-1:0] ONE   = COUNT_WIDTH'(1);

  logic [COUNT_WIDTH-1:0] period, count, period_n;
  logic                   mode_q;
  logic                   mchg, st, run, wrap, restart;

  assign period_n = wr ? period_in : period;
  assign mchg     = mode != mode_q;
  assign st       = start && enable && mode;
  assign run      = enable && (period != '0) && (!mode || busy);
  // run already excludes period==0, so period-1 never underflows when used
  assign wrap     = run && (count == period - ONE);
  assign restart  = sync || mchg || wr || st;

  always_ff @(posedge clk) begin
    if (reset) begin
      period <= DEF_P;
      count  <= '0;
      tick   <= 1'b0;
      busy   <= 1'b0;
      mode_q <= mode;
    end else begin
      period <= period_n;
      mode_q <= mode;
      tick   <= wrap && !restart;
      if (restart || !run || wrap) count <= '0;
      else                         count <= count + ONE;
      // sync leaves busy untouched; everything else follows priority order
      if (!sync) begin
        if (mchg || !enable)  busy <= 1'b0;
        else if (!mode)       busy <= (period_n != '0);
        else if (st)          busy <= 1'b1;
        else if (wrap && !wr) busy <= 1'b0;
      end
    end
  end
endmodule

module tick_generator #(
  parameter int N_CHANNELS     = 4,
  parameter int COUNT_WIDTH    = 25,
  parameter int DEFAULT_PERIOD = 25_000_000
) (
  input  logic             clk,
  input  logic             reset,
  tick_generator_if.slave  bus
);
  localparam int SEL_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

  logic [N_CHANNELS-1:0] wr_sel, tick_v, busy_v;

  // out-of-range chan_sel matches no lane
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < N_CHANNELS; i++)
      wr_sel[i] = bus.load && (bus.chan_sel == SEL_W'(i));
  end

  for (genvar gi = 0; gi < N_CHANNELS; gi++) begin : g_lane
    tick_lane #(
      .COUNT_WIDTH    (COUNT_WIDTH),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .sync      (bus.sync),
      .wr        (wr_sel[gi]),
      .period_in (bus.period_in),
      .enable    (bus.enable[gi]),
      .mode      (bus.mode[gi]),
      .start     (bus.start[gi]),
      .tick      (tick_v[gi]),
      .busy      (busy_v[gi])
    );
  end

  assign bus.tick = tick_v;
  assign bus.busy = busy_v;
endmodule

// File: tb/tb_tick_generator.sv
// Bench for tick_generator: directed scenarios with literal expectations plus a
// random run checked every cycle against a countdown-based reference model.
module tb_tick_generator;
  localparam int N   = 3;
  localparam int CW  = 8;
  localparam int DEF = 20;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  bit   chk_on = 1'b0;

  always #5 clk = ~clk;

  tick_generator_if #(.N_CHANNELS(N), .COUNT_WIDTH(CW)) bus ();

  tick_generator #(.N_CHANNELS(N), .COUNT_WIDTH(CW), .DEFAULT_PERIOD(DEF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference: per channel, cycles left until the next tick (period - elapsed).
  int          m_per  [N];
  int          m_left [N];
  logic [N-1:0] m_tick, m_busy, m_mq;

  always @(posedge clk) begin
    int  np;
    bit  wr, mchg, st, run, fire;
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        m_per[i]  <= DEF;
        m_left[i] <= DEF;
        m_tick[i] <= 1'b0;
        m_busy[i] <= 1'b0;
        m_mq[i]   <= bus.mode[i];
      end else begin
        wr   = bus.load && (int'(bus.chan_sel) == i);
        np   = wr ? int'(bus.period_in) : m_per[i];
        mchg = bus.mode[i] != m_mq[i];
        st   = bus.start[i] && bus.enable[i] && bus.mode[i];
        run  = bus.enable[i] && m_per[i] != 0 && (!bus.mode[i] || m_busy[i]);
        fire = run && m_left[i] == 1;
        m_per[i]  <= np;
        m_mq[i]   <= bus.mode[i];
        m_left[i] <= (bus.sync || mchg || wr || st || !run || fire) ? np : m_left[i] - 1;
        m_tick[i] <= fire && !bus.sync && !mchg && !wr && !st;
        if (!bus.sync) begin
          if (mchg || !bus.enable[i]) m_busy[i] <= 1'b0;
          else if (!bus.mode[i])      m_busy[i] <= (np != 0);
          else if (st)                m_busy[i] <= 1'b1;
          else if (fire && !wr)       m_busy[i] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      total++;
      if (bus.tick !== m_tick) begin
        bad++;
        $display("FAIL model_tick t=%0t got=%b exp=%b", $time, bus.tick, m_tick);
      end
      total++;
      if (bus.busy !== m_busy) begin
        bad++;
        $display("FAIL model_busy t=%0t got=%b exp=%b", $time, bus.busy, m_busy);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic ld(input int ch, input int p);
    bus.load      = 1'b1;
    bus.chan_sel  = ch[1:0];
    bus.period_in = p[CW-1:0];
  endtask

  initial begin
    int k;
    reset = 1'b1;
    bus.period_in = '0; bus.chan_sel = '0; bus.load = 1'b0;
    bus.enable = '0; bus.mode = '0; bus.start = '0; bus.sync = 1'b0;
    nxt(); chk_on = 1'b1;
    nxt();
    chk("rst_tick", int'(bus.tick), 0);
    chk("rst_busy", int'(bus.busy), 0);
    reset = 1'b0;

    // periodic P=5 on ch0
    ld(0, 5); nxt(); bus.load = 1'b0;
    bus.enable = 3'b001;
    for (int c = 1; c <= 15; c++) begin
      nxt();
      chk("p5_tick0", int'(bus.tick[0]), (c % 5 == 0) ? 1 : 0);
      chk("p5_tick1", int'(bus.tick[1]), 0);
    end
    chk("p5_busy0", int'(bus.busy[0]), 1);

    // ch1 P=1 ticks every cycle, then P=0 silences it
    ld(1, 1); bus.enable = 3'b011; nxt(); bus.load = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      nxt(); chk("p1_tick1", int'(bus.tick[1]), 1);
    end
    ld(1, 0); nxt(); bus.load = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk("p0_tick1", int'(bus.tick[1]), 0);
      chk("p0_busy1", int'(bus.busy[1]), 0);
      nxt();
    end

    // one-shot P=4 on ch0, then re-strobe mid-count
    bus.enable = 3'b001; bus.mode = 3'b001; ld(0, 4); nxt(); bus.load = 1'b0;
    nxt();
    chk("os_idle_busy", int'(bus.busy[0]), 0);
    bus.start = 3'b001; nxt(); bus.start = '0;
    for (int c = 1; c <= 10; c++) begin
      chk("os_busy", int'(bus.busy[0]), (c <= 4) ? 1 : 0);
      chk("os_tick", int'(bus.tick[0]), (c == 5) ? 1 : 0);
      nxt();
    end
    bus.start = 3'b001; nxt(); bus.start = '0;
    nxt(); nxt();
    chk("rs_mid_tick", int'(bus.tick[0]), 0);
    bus.start = 3'b001; nxt(); bus.start = '0;
    for (int c = 1; c <= 7; c++) begin
      chk("rs_busy", int'(bus.busy[0]), (c <= 4) ? 1 : 0);
      chk("rs_tick", int'(bus.tick[0]), (c == 5) ? 1 : 0);
      nxt();
    end

    // periodic P=6, load P=3 exactly on the wrap edge
    bus.mode = 3'b000; ld(0, 6); nxt(); bus.load = 1'b0;
    k = 0;
    while (!bus.tick[0] && k < 20) begin nxt(); k++; end
    chk("p6_found", (k < 20) ? 1 : 0, 1);
    for (int c = 0; c < 5; c++) nxt();
    ld(0, 3); nxt(); bus.load = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      chk("ldwrap_tick", int'(bus.tick[0]), (c == 4 || c == 7 || c == 10) ? 1 : 0);
      nxt();
    end

    // P=4 and P=6 out of phase, then sync aligns them
    ld(0, 4); nxt(); ld(1, 6); bus.enable = 3'b011; nxt(); bus.load = 1'b0;
    nxt(); nxt(); nxt();
    bus.sync = 1'b1; nxt(); bus.sync = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      if (c == 1) chk("sync_edge_tick", int'(bus.tick[1:0]), 0);
      if (c == 5) chk("sync_t0_first", int'(bus.tick[0]), 1);
      chk("sync_both", int'(bus.tick[0] && bus.tick[1]), (c == 13) ? 1 : 0);
      if (c < 13) nxt();
    end

    // reset in the middle of a one-shot
    bus.enable = 3'b001; bus.mode = 3'b001; ld(0, 4); nxt(); bus.load = 1'b0;
    bus.start = 3'b001; nxt(); bus.start = '0;
    nxt(); nxt();
    reset = 1'b1; nxt(); reset = 1'b0;
    chk("mid_rst_tick", int'(bus.tick), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    bus.enable = 3'b101;
    for (k = 1; k <= 40; k++) begin
      nxt();
      if (bus.tick[2]) break;
    end
    chk("dflt_period", k, DEF);

    // randomized traffic, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      reset         = ($urandom_range(199) == 0);
      bus.load      = ($urandom_range(5) == 0);
      bus.chan_sel  = 2'($urandom_range(3));
      bus.period_in = CW'($urandom_range(7));
      bus.sync      = ($urandom_range(39) == 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(15) == 0) bus.enable[i] = ~bus.enable[i];
        if ($urandom_range(31) == 0) bus.mode[i]   = ~bus.mode[i];
        bus.start[i] = ($urandom_range(4) == 0);
      end
      nxt();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
